// File: rtl/d7_pkg.sv
// Shared types and constants for the d7 time-multiplexed 7-segment scan driver.
package d7_pkg;

  typedef enum logic {
    BLANK  = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Active-high gfedcba glyphs for hex digits 0-F
  localparam logic [SEG_W-1:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/d7_seg_decode.sv
// Nibble to active-high gfedcba segment pattern.
module d7_seg_decode
  import d7_pkg::*;
(
  input  logic [3:0]       i_nib,
  output logic [SEG_W-1:0] o_seg_c
);

  assign o_seg_c = GLYPH[i_nib];

endmodule

// File: rtl/d7_scan_driver.sv
// Scans up to NDIG digits with a blanking gap between digits; inputs are
// snapshotted when digit 0 is lit so a frame never shows mixed data.
module d7_scan_driver
  import d7_pkg::*;
#(
  parameter int unsigned NDIG              = 8,
  parameter int unsigned DIGIT_TICKS       = 100000,
  parameter int unsigned BLANK_TICKS       = 1000,
  parameter int unsigned TURBO_DIGIT_TICKS = 4,
  parameter int unsigned TURBO_BLANK_TICKS = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              turbosim,
  input  logic [4*NDIG-1:0] bcd,
  input  logic [NDIG-1:0]   dp,
  input  logic [NDIG-1:0]   digit_en,
  input  logic              lz_blank,
  output logic [7:0]        d7_cathodes_n,
  output logic [NDIG-1:0]   d7_anodes,
  output logic              frame_start
);

  localparam int unsigned MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);
  localparam int unsigned IDX_W     = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [4*NDIG-1:0]   r_bcd;
  logic [NDIG-1:0]     r_dp;
  logic [NDIG-1:0]     r_en;
  logic                r_lz;

  logic [31:0]         w_tdig;
  logic [31:0]         w_tblk;
  logic [31:0]         w_cnt32;
  logic                w_phase_done;
  logic                w_snap;

  logic [4*NDIG-1:0]   w_src_bcd;
  logic [NDIG-1:0]     w_src_dp;
  logic [NDIG-1:0]     w_src_en;
  logic                w_src_lz;
  logic [3:0]          w_nib;
  logic [SEG_W-1:0]    w_seg;
  logic [7:0]          w_cath_pos;
  logic                w_hi_zero;
  logic                w_lit;

  logic [7:0]          w_cath_nxt;
  logic [NDIG-1:0]     w_anodes_nxt;
  logic                w_fs_nxt;

  // Phase timing; >= lets a mid-phase turbosim change terminate promptly
  assign w_tdig       = turbosim ? TURBO_DIGIT_TICKS : DIGIT_TICKS;
  assign w_tblk       = turbosim ? TURBO_BLANK_TICKS : BLANK_TICKS;
  assign w_cnt32      = 32'(r_cnt);
  assign w_phase_done = (r_state == ACTIVE) ? (w_cnt32 >= w_tdig - 32'd1)
                                            : (w_cnt32 >= w_tblk - 32'd1);
  assign w_snap       = (r_state == BLANK) && w_phase_done && (r_idx == '0);

  // Digit 0 decodes straight from the inputs being captured on this edge
  assign w_src_bcd = w_snap ? bcd      : r_bcd;
  assign w_src_dp  = w_snap ? dp       : r_dp;
  assign w_src_en  = w_snap ? digit_en : r_en;
  assign w_src_lz  = w_snap ? lz_blank : r_lz;
  assign w_nib     = w_src_bcd[4*r_idx +: 4];

  d7_seg_decode u_seg_decode (
    .i_nib   (w_nib),
    .o_seg_c (w_seg)
  );

  // All nibbles from the current digit upward are zero
  always_comb begin
    w_hi_zero = 1'b1;
    for (int unsigned j = 0; j < NDIG; j++) begin
      if ((j >= 32'(r_idx)) && (w_src_bcd[4*j +: 4] != 4'h0)) w_hi_zero = 1'b0;
    end
  end

  always_comb begin
    w_cath_pos                = '0;
    w_cath_pos[SEG_G:SEG_A]   = w_seg;
    w_cath_pos[SEG_DP]        = w_src_dp[r_idx];
    w_lit = w_src_en[r_idx] &&
            !(w_src_lz && (r_idx != '0) && w_hi_zero && !w_src_dp[r_idx]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= BLANK;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (w_phase_done) w_next_state = (r_state == BLANK) ? ACTIVE : BLANK;
  end

  always_comb begin
    w_anodes_nxt = '0;
    w_cath_nxt   = 8'hFF;
    w_fs_nxt     = 1'b0;
    if (w_next_state == ACTIVE) begin
      w_cath_nxt = ~w_cath_pos;
      w_fs_nxt   = w_snap;
      if (w_lit) w_anodes_nxt = NDIG'(1) << r_idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_bcd         <= '0;
      r_dp          <= '0;
      r_en          <= '0;
      r_lz          <= 1'b0;
      d7_anodes     <= '0;
      d7_cathodes_n <= 8'hFF;
      frame_start   <= 1'b0;
    end else begin
      r_cnt <= w_phase_done ? '0 : r_cnt + CNT_W'(1);
      if ((r_state == ACTIVE) && w_phase_done)
        r_idx <= (r_idx == IDX_W'(NDIG - 1)) ? '0 : r_idx + IDX_W'(1);
      if (w_snap) begin
        r_bcd <= bcd;
        r_dp  <= dp;
        r_en  <= digit_en;
        r_lz  <= lz_blank;
      end
      d7_anodes     <= w_anodes_nxt;
      d7_cathodes_n <= w_cath_nxt;
      frame_start   <= w_fs_nxt;
    end
  end

endmodule
